core_cycle_timer: RTL and testbench
===================================

Name: core_cycle_timer

Overview:
- Timing sequencer for one core-memory cycle, run from the 50 MHz system clock (20 ns per tick).
- Consumes a one-cycle start pulse, such as the output of the 60/100/120/200 ns delay one-shots.
- Produces read-current, sense-strobe and write-current windows, an optional read-pause-write hold (DATIP), and a completion pulse to the bus-slave control.

Parameters:
- CW, 4: width of the phase counter; every T_* below must be at most 2^CW-1.
- T_RD, 10: read-current window length in ticks (200 ns).
- T_STB, 6: sense strobe position, in ticks after rd rises; legal range 1..T_RD-1.
- T_WR, 10: write/inhibit-current window length in ticks (200 ns).
- T_REC, 5: recovery ticks after the write window (100 ns).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a cycle
- pause  in  1  sampled with an accepted start; 1 means read-pause-write
- resume  in  1  one-cycle pulse that releases PAUSE
- abort  in  1  one-cycle pulse that kills the cycle in progress
- clr_err  in  1  clears overrun
- busy  out  1  cycle in progress (READ/PAUSE/WRITE/RECOVER)
- rd  out  1  read-current window
- strobe  out  1  one-cycle sense strobe
- paused  out  1  holding between read and write
- wr  out  1  write-current window
- done  out  1  one-cycle completion pulse
- aborted  out  1  one-cycle pulse acknowledging an abort
- overrun  out  1  sticky flag: start arrived while busy

Behaviour:
- Reset, asynchronous: state IDLE, counter 0, pause latch 0, every output 0 (including overrun), immediately and independently of clk.
- States are IDLE, READ, PAUSE, WRITE, RECOVER. Outputs are registered and decoded from state/counter with no input-to-output combinational path.
- IDLE:
  - start=1 at edge E gives state READ and rd=1 from E+1, counter loaded T_RD-1, pause latched.
  - No start: the block stays in IDLE.
- READ:
  - rd is high for exactly T_RD cycles.
  - strobe is high for exactly one cycle, T_STB cycles after rd rose; rd=1 in that cycle.
  - When the counter reaches 0: latched pause=1 goes to PAUSE; otherwise the block goes to WRITE with counter T_WR-1.
- PAUSE:
  - paused=1 and busy=1, held indefinitely.
  - resume=1 goes to WRITE on the next cycle.
- WRITE: wr is high for exactly T_WR cycles, then the block goes to RECOVER with counter T_REC-1.
- RECOVER: busy=1 with rd/wr low for T_REC cycles, then IDLE.
- done:
  - High for the first IDLE cycle after RECOVER, with busy=0 in that cycle.
  - Non-pause latency, start edge to done high: T_RD+T_WR+T_REC+1 cycles (26 at defaults).
- Back-to-back: a start asserted while done=1 is accepted, with no dead cycle.
- abort:
  - In any non-IDLE state, the next cycle is IDLE: rd/wr/paused/busy go low, done is not generated, aborted=1 for one cycle.
  - In IDLE, abort is ignored. If abort and start are both high in IDLE, start is accepted.
- Simultaneous events:
  - abort with resume in PAUSE: abort wins.
  - abort in the strobe cycle: the strobe still shows that cycle, since it is registered; nothing follows it.
- start while busy: ignored, and overrun is set to 1 on the next cycle. overrun clears only through clr_err or reset. If clr_err and a new overrun occur in the same cycle, set wins.
- rd and wr are never high together. At most one of rd/paused/wr is high in any cycle.
- Counter: down-counter, no wrap — it is always reloaded before it would pass 0.
- Elaboration-time checks, failing on violation:
  - T_STB outside 1..T_RD-1.
  - Any T_* equal to 0.
  - Any T_* greater than 2^CW-1.

Decomposition:
- Shared timing package:
  - State encoding constants for IDLE/READ/PAUSE/WRITE/RECOVER.
  - TICK_NS=20.
  - A ticks-from-ns constant function.
- One sub-module, phase_timer: a loadable CW-bit down-counter with load, load_value, enable and zero outputs, and asynchronous reset. Both window lengths and the recovery period use it.

Test Plan:
- Defaults, start pulse at cycle 0, pause=0:
  - rd high cycles 1-10, strobe only at cycle 7.
  - wr high cycles 11-20, busy through cycle 25.
  - done at cycle 26 only.
- pause=1 with start at 0, resume at cycle 40:
  - paused high cycles 11-40.
  - wr high cycles 41-50.
  - done at cycle 56.
- abort at cycle 5 of a normal cycle:
  - aborted=1 at cycle 6, all outputs 0 from cycle 6.
  - No strobe and no done; a start at 10 runs normally.
- start at 0 and again at 3:
  - Second start ignored, overrun=1 from cycle 4.
  - done at 26; clr_err at 30 gives overrun=0 at 31.
- Back-to-back:
  - A start held high in the done cycle (26) gives rd high again at 27-36.
  - Second done at 52.
- Reset asserted asynchronously mid-WRITE (cycle 15, between edges): wr/busy drop immediately; after release, a start gives a normal 26-cycle cycle.

Source files
------------

// File: rtl/core_cycle_timer_pkg.sv
// Shared timing definitions for the core-memory cycle sequencer: phase
// encoding, system tick period and a nanosecond-to-tick conversion.
package core_cycle_timer_pkg;

  localparam int TICK_NS = 20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  // Rounds up so a window is never shorter than the requested analog time.
  function automatic int ticks_from_ns(input int ns);
    return (ns + TICK_NS - 1) / TICK_NS;
  endfunction

endpackage

// File: rtl/core_cycle_timer_phase_timer.sv
// Loadable down-counter that times the read, write and recovery phases.
// A load takes priority over counting; the count holds once it reaches zero.
module core_cycle_timer_phase_timer
  import core_cycle_timer_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_value_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          zero_o
);

  logic [CW-1:0] count_q, count_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement or block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/core_cycle_timer.sv
// Core-memory cycle sequencer: read window with sense strobe, optional
// read-pause-write hold, write window and recovery, all outputs registered.
module core_cycle_timer
  import core_cycle_timer_pkg::*;
#(
  parameter int CW    = 4,
  parameter int T_RD  = ticks_from_ns(200),
  parameter int T_STB = 6,
  parameter int T_WR  = ticks_from_ns(200),
  parameter int T_REC = ticks_from_ns(100)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic pause,
  input  logic resume,
  input  logic abort,
  input  logic clr_err,
  output logic busy,
  output logic rd,
  output logic strobe,
  output logic paused,
  output logic wr,
  output logic done,
  output logic aborted,
  output logic overrun
);

  localparam int T_MAX = (1 << CW) - 1;

  if (T_RD < 1 || T_WR < 1 || T_REC < 1) begin : g_bad_zero
    $fatal(1, "core_cycle_timer: T_RD, T_WR and T_REC must be non-zero");
  end
  if (T_RD > T_MAX || T_STB > T_MAX || T_WR > T_MAX || T_REC > T_MAX) begin : g_bad_width
    $fatal(1, "core_cycle_timer: a phase length does not fit in CW bits");
  end
  if (T_STB < 1 || T_STB > T_RD - 1) begin : g_bad_stb
    $fatal(1, "core_cycle_timer: T_STB must lie in 1..T_RD-1");
  end

  localparam logic [CW-1:0] RD_LOAD  = CW'(T_RD - 1);
  localparam logic [CW-1:0] WR_LOAD  = CW'(T_WR - 1);
  localparam logic [CW-1:0] REC_LOAD = CW'(T_REC - 1);
  // Count seen one cycle before the strobe cycle, so the registered strobe
  // lands T_STB cycles after rd rose.
  localparam logic [CW-1:0] STB_AT   = CW'(T_RD - T_STB);

  state_e        state_q, state_d;
  logic          pause_q, pause_d;
  logic          tmr_load, tmr_en, tmr_zero;
  logic [CW-1:0] tmr_value, tmr_count;
  logic          busy_q, rd_q, strobe_q, paused_q, wr_q, done_q, aborted_q, overrun_q;
  logic          is_active, kill, ovr_set;

  assign is_active = (state_q != ST_IDLE);
  assign kill      = abort && is_active;
  assign ovr_set   = start && is_active;

  core_cycle_timer_phase_timer #(
    .CW (CW)
  ) u_phase_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (tmr_load),
    .load_value_i (tmr_value),
    .en_i         (tmr_en),
    .count_o      (tmr_count),
    .zero_o       (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    pause_d   = pause_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_READ;
          pause_d   = pause;
          tmr_load  = 1'b1;
          tmr_value = RD_LOAD;
        end
      end
      ST_READ: begin
        if (!tmr_zero) begin
          tmr_en = 1'b1;
        end else if (pause_q) begin
          state_d = ST_PAUSE;
        end else begin
          state_d   = ST_WRITE;
          tmr_load  = 1'b1;
          tmr_value = WR_LOAD;
        end
      end
      ST_PAUSE: begin
        if (resume) begin
          state_d   = ST_WRITE;
          tmr_load  = 1'b1;
          tmr_value = WR_LOAD;
        end
      end
      ST_WRITE: begin
        if (!tmr_zero) begin
          tmr_en = 1'b1;
        end else begin
          state_d   = ST_RECOVER;
          tmr_load  = 1'b1;
          tmr_value = REC_LOAD;
        end
      end
      ST_RECOVER: begin
        if (!tmr_zero) begin
          tmr_en = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides every transition above, including a pending resume.
    if (kill) begin
      state_d   = ST_IDLE;
      pause_d   = 1'b0;
      tmr_load  = 1'b1;
      tmr_value = '0;
      tmr_en    = 1'b0;
    end
  end

  // Outputs are decoded from next state so each window starts on the same
  // edge as its phase, with no input reaching an output combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pause_q   <= 1'b0;
      busy_q    <= 1'b0;
      rd_q      <= 1'b0;
      strobe_q  <= 1'b0;
      paused_q  <= 1'b0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pause_q   <= pause_d;
      busy_q    <= (state_d != ST_IDLE);
      rd_q      <= (state_d == ST_READ);
      strobe_q  <= (state_q == ST_READ) && (tmr_count == STB_AT) && !kill;
      paused_q  <= (state_d == ST_PAUSE);
      wr_q      <= (state_d == ST_WRITE);
      done_q    <= (state_q == ST_RECOVER) && tmr_zero && !kill;
      aborted_q <= kill;
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (clr_err) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign busy    = busy_q;
  assign rd      = rd_q;
  assign strobe  = strobe_q;
  assign paused  = paused_q;
  assign wr      = wr_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_core_cycle_timer.sv
// Bench for core_cycle_timer: directed cycle scenarios with literal
// expectations, then random traffic against a timestamp-based cycle model.
module tb_core_cycle_timer;

  localparam int T_RD  = 10;
  localparam int T_STB = 6;
  localparam int T_WR  = 10;
  localparam int T_REC = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, pause = 1'b0, resume = 1'b0, abort = 1'b0, clr_err = 1'b0;
  logic busy, rd, strobe, paused, wr, done, aborted, overrun;

  int total = 0;
  int bad   = 0;

  core_cycle_timer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pause   (pause),
    .resume  (resume),
    .abort   (abort),
    .clr_err (clr_err),
    .busy    (busy),
    .rd      (rd),
    .strobe  (strobe),
    .paused  (paused),
    .wr      (wr),
    .done    (done),
    .aborted (aborted),
    .overrun (overrun)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Model: an accepted start at cycle t0 fixes every window by arithmetic.
  // m_wr0 is the first write cycle, or -1 while waiting for a resume.
  int   m_cyc = 0, m_t0 = 0, m_wr0 = -1, mn = 0, mm = 0;
  bit   m_active = 1'b0, was_act = 1'b0;
  logic e_busy = 1'b0, e_rd = 1'b0, e_strobe = 1'b0, e_paused = 1'b0, e_wr = 1'b0;
  logic e_done = 1'b0, e_aborted = 1'b0, e_ovr = 1'b0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_cyc = 0; m_active = 1'b0; m_t0 = 0; m_wr0 = -1;
      {e_busy, e_rd, e_strobe, e_paused, e_wr, e_done, e_aborted, e_ovr} = '0;
    end else begin
      mn = m_cyc;
      mm = mn + 1;
      was_act   = m_active;
      e_done    = 1'b0;
      e_aborted = 1'b0;
      if (m_active && abort) begin
        m_active  = 1'b0;
        e_aborted = 1'b1;
      end else if (m_active && resume && m_wr0 < 0 && mn > m_t0 + T_RD) begin
        m_wr0 = mm;
      end
      if (!was_act && start) begin
        m_active = 1'b1;
        m_t0     = mn;
        m_wr0    = pause ? -1 : mn + T_RD + 1;
      end
      if (m_active && m_wr0 >= 0 && mm == m_wr0 + T_WR + T_REC) begin
        m_active = 1'b0;
        e_done   = 1'b1;
      end
      if (start && was_act) e_ovr = 1'b1;
      else if (clr_err)     e_ovr = 1'b0;
      e_busy   = m_active;
      e_rd     = m_active && mm > m_t0 && mm <= m_t0 + T_RD;
      e_strobe = m_active && mm == m_t0 + 1 + T_STB;
      e_paused = m_active && mm > m_t0 + T_RD && (m_wr0 < 0 || mm < m_wr0);
      e_wr     = m_active && m_wr0 >= 0 && mm >= m_wr0 && mm < m_wr0 + T_WR;
      m_cyc    = mm;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("busy", busy, e_busy);
      check("rd", rd, e_rd);
      check("strobe", strobe, e_strobe);
      check("paused", paused, e_paused);
      check("wr", wr, e_wr);
      check("done", done, e_done);
      check("aborted", aborted, e_aborted);
      check("overrun", overrun, e_ovr);
      check("one_hot_window", 32'(rd) + 32'(paused) + 32'(wr) <= 1, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0; pause = 1'b0; resume = 1'b0; abort = 1'b0; clr_err = 1'b0;
  endtask

  task automatic drive(input int id, input int rc);
    case (id)
      0, 5: start = (rc == 0);
      1: begin start = (rc == 0); pause = (rc == 0); resume = (rc == 40); end
      2: begin start = (rc == 0 || rc == 10); abort = (rc == 5); end
      3: begin start = (rc == 0 || rc == 3); clr_err = (rc == 30); end
      4: start = (rc == 0 || rc == 26);
      default: ;
    endcase
  endtask

  task automatic lit_check(input int id, input int rc);
    case (id)
      0: begin
        if (rc == 0)  check("a_idle_busy", busy, 0);
        if (rc == 1)  check("a_rd_rise", rd, 1);
        if (rc == 6)  check("a_no_early_stb", strobe, 0);
        if (rc == 7)  begin check("a_strobe", strobe, 1); check("a_stb_rd", rd, 1);
                            check("a_model_stb", e_strobe, 1); end
        if (rc == 10) check("a_rd_last", rd, 1);
        if (rc == 11) begin check("a_wr_rise", wr, 1); check("a_rd_fall", rd, 0); end
        if (rc == 20) check("a_wr_last", wr, 1);
        if (rc == 21) begin check("a_wr_fall", wr, 0); check("a_rec_busy", busy, 1); end
        if (rc == 25) check("a_rec_last", busy, 1);
        if (rc == 26) begin check("a_done", done, 1); check("a_done_busy", busy, 0);
                            check("a_model_done", e_done, 1); end
        if (rc == 27) check("a_done_once", done, 0);
      end
      1: begin
        if (rc == 10) check("b_rd_last", rd, 1);
        if (rc == 11) check("b_paused_rise", paused, 1);
        if (rc == 40) begin check("b_paused_last", paused, 1); check("b_no_wr", wr, 0); end
        if (rc == 41) begin check("b_wr_rise", wr, 1); check("b_paused_fall", paused, 0); end
        if (rc == 50) check("b_wr_last", wr, 1);
        if (rc == 51) check("b_wr_fall", wr, 0);
        if (rc == 56) begin check("b_done", done, 1); check("b_model_done", e_done, 1); end
      end
      2: begin
        if (rc == 6)  begin check("c_aborted", aborted, 1); check("c_busy", busy, 0);
                            check("c_rd", rd, 0); end
        if (rc == 7)  begin check("c_no_strobe", strobe, 0); check("c_ack_once", aborted, 0); end
        if (rc == 11) check("c_restart_rd", rd, 1);
        if (rc == 26) check("c_no_done", done, 0);
        if (rc == 36) check("c_restart_done", done, 1);
      end
      3: begin
        if (rc == 3)  check("d_ovr_clear", overrun, 0);
        if (rc == 4)  check("d_ovr_set", overrun, 1);
        if (rc == 26) begin check("d_done", done, 1); check("d_ovr_sticky", overrun, 1); end
        if (rc == 31) check("d_ovr_cleared", overrun, 0);
      end
      4: begin
        if (rc == 26) check("e_done1", done, 1);
        if (rc == 27) check("e_rd_again", rd, 1);
        if (rc == 36) check("e_rd_last", rd, 1);
        if (rc == 37) begin check("e_rd_fall", rd, 0); check("e_wr", wr, 1); end
        if (rc == 52) check("e_done2", done, 1);
      end
      5: if (rc == 14) check("f_wr_before_reset", wr, 1);
      default: ;
    endcase
  endtask

  task automatic run_test(input int id, input int len);
    for (int rc = 0; rc < len; rc++) begin
      drive(id, rc);
      @(negedge clk);
      lit_check(id, rc);
      tick();
    end
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd", rd, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    run_test(0, 28);
    run_test(1, 58);
    run_test(2, 38);
    run_test(3, 33);
    run_test(4, 54);
    run_test(5, 15);

    // Now 1 ns into cycle 15 (mid-WRITE); assert reset between edges.
    #3 reset = 1'b1;
    #1;
    check("f_wr_async", wr, 0);
    check("f_busy_async", busy, 0);
    check("f_rd_async", rd, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    run_test(0, 28);

    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 9) == 0);
      pause   = $urandom_range(0, 1) == 1;
      resume  = ($urandom_range(0, 19) == 0);
      abort   = ($urandom_range(0, 49) == 0);
      clr_err = ($urandom_range(0, 29) == 0);
      tick();
    end
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
